// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the two-port RAM arbiter: port 0 is the core, port 1 the
// loader/DMA master. The arbiter takes the slave view, requesters the master view.
interface mem_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          req0,   req1;
    logic          we0,    we1;
    logic          lock0,  lock1;
    logic [AW-1:0] addr0,  addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0,   gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          err0,   err1;

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
    );

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with per-port lock sharing one synchronous single-port RAM
// (1-cycle read latency); routes read data back to the issuing port and flags bad addresses.
module mem_arbiter #(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int DEPTH = 64,
    parameter int WRAP  = 0,
    localparam int RAW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus,
    output logic            ram_en,
    output logic            ram_we,
    output logic [RAW-1:0]  ram_addr,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata
);
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {ST_FREE, ST_OWN0, ST_OWN1} own_state_t;

    own_state_t    state, state_d;
    logic          last;
    logic          gnt_vld, win;
    logic          sel_we, sel_lock, sel_ok;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          pend_vld_p1, pend_port_p1, pend_oor_p1;
    logic          err0_p1, err1_p1;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic          ret0, ret1;
    logic [DW-1:0] ret_data;

    function automatic logic in_range(input logic [AW-1:0] a);
        return (WRAP != 0) || ({1'b0, a} < DEPTH_X);
    endfunction

    // Arbitration: a requesting owner always wins; otherwise the port that did not win last.
    always_comb begin
        gnt_vld = 1'b0;
        win     = 1'b0;
        state_d = ST_FREE;
        if (!rst) begin
            if (state == ST_OWN0 && bus.req0) begin
                gnt_vld = 1'b1;
                win     = 1'b0;
            end else if (state == ST_OWN1 && bus.req1) begin
                gnt_vld = 1'b1;
                win     = 1'b1;
            end else if (bus.req0 && bus.req1) begin
                gnt_vld = 1'b1;
                win     = ~last;
            end else if (bus.req0) begin
                gnt_vld = 1'b1;
                win     = 1'b0;
            end else if (bus.req1) begin
                gnt_vld = 1'b1;
                win     = 1'b1;
            end
        end
        sel_we    = win ? bus.we1    : bus.we0;
        sel_lock  = win ? bus.lock1  : bus.lock0;
        sel_addr  = win ? bus.addr1  : bus.addr0;
        sel_wdata = win ? bus.wdata1 : bus.wdata0;
        sel_ok    = in_range(sel_addr);
        // Without a grant nobody requests, so any owner has dropped req and is released.
        if (gnt_vld && sel_lock)
            state_d = win ? ST_OWN1 : ST_OWN0;
    end

    assign bus.gnt0  = gnt_vld & ~win;
    assign bus.gnt1  = gnt_vld &  win;
    assign ram_en    = gnt_vld & sel_ok;
    assign ram_we    = gnt_vld & sel_we;
    assign ram_addr  = gnt_vld ? sel_addr[RAW-1:0] : '0;
    assign ram_wdata = gnt_vld ? sel_wdata : '0;

    // Stage p0 -> p1: tag accepted reads and latch range errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_FREE;
            last        <= 1'b1;
            pend_vld_p1 <= 1'b0;
            err0_p1     <= 1'b0;
            err1_p1     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state       <= state_d;
            if (gnt_vld)
                last <= win;
            pend_vld_p1 <= gnt_vld & ~sel_we;
            err0_p1     <= gnt_vld & ~win & ~sel_ok;
            err1_p1     <= gnt_vld &  win & ~sel_ok;
            if (ret0)
                rdata0_q <= ret_data;
            if (ret1)
                rdata1_q <= ret_data;
        end
    end

    always_ff @(posedge clk) begin
        pend_port_p1 <= win;
        pend_oor_p1  <= ~sel_ok;
    end

    // Stage p1: RAM output arrives; steer it to the tagged port, others hold.
    assign ret0        = pend_vld_p1 & ~pend_port_p1;
    assign ret1        = pend_vld_p1 &  pend_port_p1;
    assign ret_data    = pend_oor_p1 ? '0 : ram_rdata;
    assign bus.rvalid0 = ret0;
    assign bus.rvalid1 = ret1;
    assign bus.rdata0  = ret0 ? ret_data : rdata0_q;
    assign bus.rdata1  = ret1 ? ret_data : rdata1_q;
    assign bus.err0    = err0_p1;
    assign bus.err1    = err1_p1;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences and
// random traffic checked against a rule-level reference model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    mem_arbiter_if #(.DW(16), .AW(16)) bus();
    mem_arbiter_if #(.DW(16), .AW(16)) wbus();

    logic        ram_en, ram_we, w_ram_en, w_ram_we;
    logic [5:0]  ram_addr, w_ram_addr;
    logic [15:0] ram_wdata, ram_rdata, w_ram_wdata, w_ram_rdata;

    mem_arbiter #(.DW(16), .AW(16), .DEPTH(64), .WRAP(0)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_arbiter #(.DW(16), .AW(16), .DEPTH(64), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .bus(wbus),
        .ram_en(w_ram_en), .ram_we(w_ram_we), .ram_addr(w_ram_addr),
        .ram_wdata(w_ram_wdata), .ram_rdata(w_ram_rdata)
    );

    function automatic logic [15:0] init_word(input int i);
        return (i == 5) ? 16'h1234 : (16'hA000 | 16'(i));
    endfunction

    // Synchronous RAMs behind each arbiter
    logic [15:0] ram [64];
    logic [15:0] wram [64];
    logic        init_ram;
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 64; i++) begin
                ram[i]  <= init_word(i);
                wram[i] <= init_word(i);
            end
        end else begin
            if (ram_en) begin
                if (ram_we) ram[ram_addr] <= ram_wdata;
                else        ram_rdata     <= ram[ram_addr];
            end
            if (w_ram_en) begin
                if (w_ram_we) wram[w_ram_addr] <= w_ram_wdata;
                else          w_ram_rdata      <= wram[w_ram_addr];
            end
        end
    end

    typedef struct {
        logic [1:0]  req, we, lock;
        logic [15:0] a0, a1, d0, d1;
        logic [1:0]  gnt;
        logic        en;
        logic [1:0]  rv, err;
        logic [15:0] rd0, rd1;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] req, we, lock,
                                input logic [15:0] a0, a1, d0, d1,
                                input logic [1:0] gnt, input logic en,
                                input logic [1:0] rv, err,
                                input logic [15:0] rd0, rd1);
        vec_t v;
        v.req = req; v.we = we; v.lock = lock;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.gnt = gnt; v.en = en; v.rv = rv; v.err = err; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model state: who won last, who owns, memory image, last data per port
    int          m_last, m_own;
    logic [15:0] m_mem [64];
    logic [15:0] m_rd [2];

    logic [1:0]  obs_gnt, obs_rv, obs_err;
    logic        obs_en;
    logic [15:0] obs_rd0, obs_rd1;

    task automatic drive(input vec_t v);
        bus.req0 = v.req[0]; bus.we0 = v.we[0]; bus.lock0 = v.lock[0];
        bus.addr0 = v.a0; bus.wdata0 = v.d0;
        bus.req1 = v.req[1]; bus.we1 = v.we[1]; bus.lock1 = v.lock[1];
        bus.addr1 = v.a1; bus.wdata1 = v.d1;
    endtask

    task automatic model_reset();
        m_last = 1; m_own = -1; m_rd[0] = 16'h0; m_rd[1] = 16'h0;
    endtask

    // One cycle starting at a falling edge: drive, check the command, clock, check the return.
    task automatic step(input vec_t v);
        int          win;
        logic        inr;
        logic [15:0] a [2];
        logic [15:0] d [2];
        logic [1:0]  exp_rv, exp_err, exp_gnt;
        drive(v);
        a[0] = v.a0; a[1] = v.a1; d[0] = v.d0; d[1] = v.d1;
        win = -1;
        if (m_own >= 0 && v.req[m_own]) win = m_own;
        else if (v.req == 2'b11)        win = 1 - m_last;
        else if (v.req[0])              win = 0;
        else if (v.req[1])              win = 1;
        inr = 1'b0;
        exp_gnt = 2'b00;
        if (win >= 0) begin
            inr = (a[win] < 16'd64);
            exp_gnt[win] = 1'b1;
        end
        #1;
        obs_gnt = {bus.gnt1, bus.gnt0};
        obs_en  = ram_en;
        chk("model gnt", 32'(obs_gnt), 32'(exp_gnt));
        chk("model ram_en", 32'(obs_en), 32'(inr));
        if (inr) begin
            chk("model ram_addr", 32'(ram_addr), 32'(a[win][5:0]));
            chk("model ram_we", 32'(ram_we), 32'(v.we[win]));
            if (v.we[win]) chk("model ram_wdata", 32'(ram_wdata), 32'(d[win]));
        end
        @(posedge clk);
        exp_rv = 2'b00; exp_err = 2'b00;
        if (win >= 0) begin
            if (!v.we[win]) begin
                exp_rv[win] = 1'b1;
                m_rd[win] = inr ? m_mem[a[win][5:0]] : 16'h0;
            end else if (inr) begin
                m_mem[a[win][5:0]] = d[win];
            end
            exp_err[win] = !inr;
            m_last = win;
            m_own  = v.lock[win] ? win : -1;
        end else if (m_own >= 0 && !v.req[m_own]) begin
            m_own = -1;
        end
        #1;
        obs_rv  = {bus.rvalid1, bus.rvalid0};
        obs_err = {bus.err1, bus.err0};
        obs_rd0 = bus.rdata0;
        obs_rd1 = bus.rdata1;
        chk("model rvalid", 32'(obs_rv), 32'(exp_rv));
        chk("model err", 32'(obs_err), 32'(exp_err));
        chk("model rdata0", 32'(obs_rd0), 32'(m_rd[0]));
        chk("model rdata1", 32'(obs_rd1), 32'(m_rd[1]));
        @(negedge clk);
    endtask

    task automatic do_reset();
        vec_t z;
        z = mk(2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0, 2'b00, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0);
        rst = 1'b1;
        drive(z);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    vec_t tbl [20];
    vec_t r;
    logic [1:0] pend;

    initial begin
        rst = 1'b1;
        init_ram = 1'b1;
        for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);
        model_reset();
        wbus.req0 = 1'b0; wbus.we0 = 1'b0; wbus.lock0 = 1'b0; wbus.addr0 = 16'h0; wbus.wdata0 = 16'h0;
        wbus.req1 = 1'b0; wbus.we1 = 1'b0; wbus.lock1 = 1'b0; wbus.addr1 = 16'h0; wbus.wdata1 = 16'h0;
        r = mk(2'b11, 2'b00, 2'b00, 16'd1, 16'd2, 16'd0, 16'd0, 2'b00, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0);
        drive(r);

        // Reset state while both ports request
        @(posedge clk);
        @(negedge clk);
        chk("reset gnt0", 32'(bus.gnt0), 32'd0);
        chk("reset gnt1", 32'(bus.gnt1), 32'd0);
        chk("reset ram_en", 32'(ram_en), 32'd0);
        chk("reset rvalid", 32'({bus.rvalid1, bus.rvalid0}), 32'd0);
        chk("reset rdata0", 32'(bus.rdata0), 32'd0);
        chk("reset rdata1", 32'(bus.rdata1), 32'd0);
        chk("reset err", 32'({bus.err1, bus.err0}), 32'd0);
        init_ram = 1'b0;
        do_reset();

        // Single read from port 0
        step(mk(2'b01, 2'b00, 2'b00, 16'd5, 16'd0, 16'd0, 16'd0, 2'b00, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0));
        chk("single gnt0", 32'(obs_gnt), 32'h1);
        chk("single rvalid0", 32'(obs_rv[0]), 32'd1);
        chk("single rdata0", 32'(obs_rd0), 32'h1234);
        chk("single rvalid1", 32'(obs_rv[1]), 32'd0);
        do_reset();

        // Directed vectors with hand-derived expectations (bit0 = port 0)
        tbl[0]  = mk(2'b11, 2'b00, 2'b00, 16'd10, 16'd20, 16'd0, 16'd0, 2'b01, 1'b1, 2'b01, 2'b00, 16'hA00A, 16'h0000);
        tbl[1]  = mk(2'b11, 2'b00, 2'b00, 16'd10, 16'd20, 16'd0, 16'd0, 2'b10, 1'b1, 2'b10, 2'b00, 16'hA00A, 16'hA014);
        tbl[2]  = mk(2'b11, 2'b00, 2'b00, 16'd10, 16'd20, 16'd0, 16'd0, 2'b01, 1'b1, 2'b01, 2'b00, 16'hA00A, 16'hA014);
        tbl[3]  = mk(2'b11, 2'b00, 2'b00, 16'd10, 16'd20, 16'd0, 16'd0, 2'b10, 1'b1, 2'b10, 2'b00, 16'hA00A, 16'hA014);
        tbl[4]  = mk(2'b11, 2'b00, 2'b00, 16'd10, 16'd20, 16'd0, 16'd0, 2'b01, 1'b1, 2'b01, 2'b00, 16'hA00A, 16'hA014);
        tbl[5]  = mk(2'b11, 2'b00, 2'b00, 16'd10, 16'd20, 16'd0, 16'd0, 2'b10, 1'b1, 2'b10, 2'b00, 16'hA00A, 16'hA014);
        tbl[6]  = mk(2'b01, 2'b00, 2'b00, 16'd11, 16'd30, 16'd0, 16'd0, 2'b01, 1'b1, 2'b01, 2'b00, 16'hA00B, 16'hA014);
        tbl[7]  = mk(2'b11, 2'b00, 2'b10, 16'd11, 16'd30, 16'd0, 16'd0, 2'b10, 1'b1, 2'b10, 2'b00, 16'hA00B, 16'hA01E);
        tbl[8]  = mk(2'b11, 2'b00, 2'b10, 16'd11, 16'd30, 16'd0, 16'd0, 2'b10, 1'b1, 2'b10, 2'b00, 16'hA00B, 16'hA01E);
        tbl[9]  = mk(2'b11, 2'b00, 2'b10, 16'd11, 16'd30, 16'd0, 16'd0, 2'b10, 1'b1, 2'b10, 2'b00, 16'hA00B, 16'hA01E);
        tbl[10] = mk(2'b11, 2'b00, 2'b00, 16'd11, 16'd30, 16'd0, 16'd0, 2'b10, 1'b1, 2'b10, 2'b00, 16'hA00B, 16'hA01E);
        tbl[11] = mk(2'b11, 2'b00, 2'b00, 16'd11, 16'd30, 16'd0, 16'd0, 2'b01, 1'b1, 2'b01, 2'b00, 16'hA00B, 16'hA01E);
        tbl[12] = mk(2'b11, 2'b00, 2'b10, 16'd11, 16'd30, 16'd0, 16'd0, 2'b10, 1'b1, 2'b10, 2'b00, 16'hA00B, 16'hA01E);
        tbl[13] = mk(2'b01, 2'b00, 2'b00, 16'd11, 16'd30, 16'd0, 16'd0, 2'b01, 1'b1, 2'b01, 2'b00, 16'hA00B, 16'hA01E);
        tbl[14] = mk(2'b11, 2'b00, 2'b00, 16'd11, 16'd30, 16'd0, 16'd0, 2'b10, 1'b1, 2'b10, 2'b00, 16'hA00B, 16'hA01E);
        tbl[15] = mk(2'b01, 2'b01, 2'b00, 16'hFFFF, 16'd30, 16'hBEEF, 16'd0, 2'b01, 1'b0, 2'b00, 2'b01, 16'hA00B, 16'hA01E);
        tbl[16] = mk(2'b10, 2'b00, 2'b00, 16'd0, 16'd64, 16'd0, 16'd0, 2'b10, 1'b0, 2'b10, 2'b10, 16'hA00B, 16'h0000);
        tbl[17] = mk(2'b01, 2'b01, 2'b00, 16'd3, 16'd0, 16'h00AA, 16'd0, 2'b01, 1'b1, 2'b00, 2'b00, 16'hA00B, 16'h0000);
        tbl[18] = mk(2'b10, 2'b00, 2'b00, 16'd0, 16'd3, 16'd0, 16'd0, 2'b10, 1'b1, 2'b10, 2'b00, 16'hA00B, 16'h00AA);
        tbl[19] = mk(2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0, 2'b00, 1'b0, 2'b00, 2'b00, 16'hA00B, 16'h00AA);
        for (int i = 0; i < 20; i++) begin
            step(tbl[i]);
            chk($sformatf("vec%0d gnt", i), 32'(obs_gnt), 32'(tbl[i].gnt));
            chk($sformatf("vec%0d ram_en", i), 32'(obs_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d rvalid", i), 32'(obs_rv), 32'(tbl[i].rv));
            chk($sformatf("vec%0d err", i), 32'(obs_err), 32'(tbl[i].err));
            chk($sformatf("vec%0d rdata0", i), 32'(obs_rd0), 32'(tbl[i].rd0));
            chk($sformatf("vec%0d rdata1", i), 32'(obs_rd1), 32'(tbl[i].rd1));
        end

        // WRAP=1 instance: 65535 aliases word 63, never an error
        wbus.req0 = 1'b1; wbus.we0 = 1'b1; wbus.addr0 = 16'hFFFF; wbus.wdata0 = 16'h5555;
        #1;
        chk("wrap wr gnt0", 32'(wbus.gnt0), 32'd1);
        chk("wrap wr ram_en", 32'(w_ram_en), 32'd1);
        chk("wrap wr ram_addr", 32'(w_ram_addr), 32'd63);
        @(posedge clk); #1;
        chk("wrap wr err0", 32'(wbus.err0), 32'd0);
        @(negedge clk);
        wbus.we0 = 1'b0;
        #1;
        chk("wrap rd ram_addr", 32'(w_ram_addr), 32'd63);
        @(posedge clk); #1;
        chk("wrap rd rvalid0", 32'(wbus.rvalid0), 32'd1);
        chk("wrap rd rdata0", 32'(wbus.rdata0), 32'h5555);
        chk("wrap rd err0", 32'(wbus.err0), 32'd0);
        @(negedge clk);
        wbus.req0 = 1'b0;

        // Reset arriving the cycle after a read is accepted
        drive(mk(2'b01, 2'b00, 2'b00, 16'd5, 16'd0, 16'd0, 16'd0, 2'b00, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0));
        #1;
        chk("midrst gnt0 before", 32'(bus.gnt0), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst rvalid0", 32'(bus.rvalid0), 32'd0);
        chk("midrst rdata", 32'({bus.rdata1, bus.rdata0}), 32'd0);
        chk("midrst gnt0", 32'(bus.gnt0), 32'd0);
        chk("midrst ram_en", 32'(ram_en), 32'd0);
        @(posedge clk); #1;
        chk("midrst rvalid0 held", 32'(bus.rvalid0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(mk(2'b11, 2'b00, 2'b00, 16'd7, 16'd8, 16'd0, 16'd0, 2'b00, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0));
        chk("midrst first tie", 32'(obs_gnt), 32'h1);

        // Random traffic; a refused request is held unchanged until granted
        pend = 2'b00;
        r = mk(2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0, 2'b00, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0);
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    logic [15:0] ra, rd;
                    ra = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
                    rd = 16'($urandom);
                    r.req[p]  = ($urandom_range(0, 3) != 0);
                    r.we[p]   = $urandom_range(0, 1) != 0;
                    r.lock[p] = ($urandom_range(0, 3) == 0);
                    if (p == 0) begin r.a0 = ra; r.d0 = rd; end
                    else        begin r.a1 = ra; r.d1 = rd; end
                end
            end
            step(r);
            for (int p = 0; p < 2; p++) pend[p] = r.req[p] && !obs_gnt[p];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 16-bit data RAM (stack, `cal`/`ret`, `lod`/`str` storage) between the `risccpu` core (port 0) and a second bus master (port 1: debug loader or IO DMA). Each cycle it issues at most one access to a synchronous RAM with 1-cycle read latency, using round-robin arbitration with an optional per-port lock. It routes read data back to the issuing port and flags out-of-range addresses.

## Interface
- `DW`, 16: data width of ports and RAM.
- `AW`, 16: requester address width.
- `DEPTH`, 64: RAM words; `RAW = $clog2(DEPTH)`.
- `WRAP`, 0: 1 means addresses are taken modulo `DEPTH` and never error; 0 means any `addr >= DEPTH` is an error.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req0`/`req1` in 1: access request.
- `we0`/`we1` in 1: 1 = write, 0 = read.
- `lock0`/`lock1` in 1: hold ownership after this access.
- `addr0`/`addr1` in AW: word address.
- `wdata0`/`wdata1` in DW: write data.
- `gnt0`/`gnt1` out 1: request accepted this cycle (combinational).
- `rvalid0`/`rvalid1` out 1: read data valid, registered.
- `rdata0`/`rdata1` out DW: read data, registered.
- `err0`/`err1` out 1: one-cycle error pulse for an out-of-range access, registered.
- `ram_en` out 1, `ram_we` out 1, `ram_addr` out RAW, `ram_wdata` out DW: RAM command (combinational).
- `ram_rdata` in DW: RAM output, valid one cycle after a read command.

## Operation
- Transfer: port n is accepted when `reqn & gntn` is high at a rising edge. A requester holds `req`/`we`/`addr`/`wdata` stable until granted.
- Arbitration: `gnt` is asserted to exactly one port or none.
  - Only one port requesting: that port wins.
  - Both requesting: the port that is not `last` wins. `last` updates to the winner on every accepted transfer.
- Lock: a port accepted with `lockn=1` becomes owner (`own_valid=1`, `own=n`).
  - While the owner keeps `req` high, only the owner is granted. The other port waits with gnt=0.
  - Ownership is released on the first cycle the owner has `req=0`, or on an accepted transfer with `lock=0`.
  - Lock exists so `cal`/`ret`/`pop` sequences complete atomically.
- Range check (WRAP=0): an accepted access with `addr >= DEPTH` is still granted, but `ram_en=0`.
  - Write: dropped; `errn=1` next cycle.
  - Read: `rvalidn=1`, `rdatan=0`, `errn=1` next cycle.
- WRAP=1: `ram_addr = addr[RAW-1:0]`; `err` never asserts.
- RAM command: `ram_en = accepted & in-range`; `ram_we = winner we`; address/data come from the winner. With no grant: `ram_en=0` and other RAM outputs are 0.
- Read return: a pipeline tag register (`pend_valid`, `pend_port`, `pend_err`) captures each accepted read.
  - Next cycle, the tagged port gets `rvalid=1` and `rdata = pend_err ? 0 : ram_rdata`.
  - The non-tagged port's `rdata` holds its previous value.
- Writes produce no `rvalid`.

## Timing
- Reset values: `rvalid0/1=0`, `rdata0/1=0`, `err0/1=0`, `last=1` (port 0 wins the first tie), `own_valid=0`, `pend_valid=0`.
- Combinational outputs during reset: `gnt0/1=0`, `ram_en=0`.
- Grant latency: 0 cycles (same cycle as `req` when the port wins).
- Read latency: `rvalid` exactly 1 cycle after acceptance. Throughput is one access per cycle; back-to-back reads from alternating ports each return on the following cycle.
- Simultaneous events:
  - Owner releases (`req=0`) while the other port requests: the other port is granted in that same cycle.
  - Owner accepts with `lock=0` while the other port requests: normal round-robin applies from the next cycle.
- Reset mid-operation: pending read is discarded, no `rvalid` is produced, ownership is cleared.
- Write then read of the same address on consecutive cycles returns the new data (the RAM's write completes at the edge).

## Test plan
- Single read, port 0, addr 5, RAM holds 0x1234: `gnt0=1` in cycle 0; `rvalid0=1`, `rdata0=0x1234` in cycle 1; `rvalid1=0`.
- Both ports request reads every cycle for 6 cycles after reset: grants go 0,1,0,1,0,1. Each `rvalid` appears on the correct port one cycle later with that port's data.
- Port 1 locks with `lock1=1` for 3 accesses while `req0` is held high: `gnt0=0` for those 3 cycles. After port 1 drops `lock1`, the next grant goes to port 0.
- WRAP=0, DEPTH=64:
  - Write 0xBEEF to 65535: `gnt=1`, `ram_en=0`, `err` pulse next cycle.
  - Read 64: `rvalid=1`, `rdata=0`, `err=1`.
  - WRAP=1: a read of 65535 accesses word 63.
- Write 0x00AA to addr 3 (port 0), then read addr 3 (port 1) on the next cycle: `rdata1=0x00AA`.
- Assert `rst` one cycle after a read is accepted: no `rvalid`; all outputs return to reset values immediately (asynchronous); the first tie after release is granted to port 0.
